// File: rtl/rv32i_types_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv32i_types_pkg : shared types for the vector lane sequencer       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package rv32i_types_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_MC = 2'd2,
    FIN     = 2'd3
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/vseq_done_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vseq_done_tracker : sticky per-lane done flags and all-done compare|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vseq_done_tracker (
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic [1:0] load_pend,
  input  logic       track,
  input  logic       clear,
  input  logic [1:0] lane_done,
  output logic [1:0] pend,
  output logic       all_done
);

  logic [1:0] pend_r;
  logic [1:0] got_r;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_r <= 2'b00;
      got_r  <= 2'b00;
    end else if (load) begin
      pend_r <= load_pend;
      got_r  <= 2'b00;
    end else if (clear) begin
      pend_r <= 2'b00;
      got_r  <= 2'b00;
    end else if (track) begin
      // Lanes that were never started cannot contribute a completion.
      got_r <= got_r | (lane_done & pend_r);
    end
  end

  assign pend     = pend_r;
  assign all_done = (pend_r != 2'b00) && (((got_r | lane_done) & pend_r) == pend_r);

endmodule
`default_nettype wire

// File: rtl/vector_lane_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vector_lane_sequencer : two-lane element-group sequencer           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vector_lane_sequencer
  import rv32i_types_pkg::*;
#(
  parameter int MAX_VL = 32,
  parameter int VL_W   = $clog2(MAX_VL) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              instr_valid,
  output logic              ready,
  input  logic [VL_W-1:0]   vl,
  input  logic              vm,
  input  logic              fu_multicycle,
  input  logic [MAX_VL-1:0] mask_bits,
  input  logic              stall,
  input  logic [1:0]        lane_done,
  input  logic [1:0]        lane_exception,
  output logic [VL_W-1:0]   offset,
  output logic [1:0]        lane_active,
  output logic [1:0]        lane_start,
  output logic [1:0]        wen,
  output logic              busy,
  output logic              done,
  output logic              exception,
  output logic [VL_W-1:0]   vstart_out
);

  seq_state_t        state;
  logic [VL_W-1:0]   offset_r;
  logic [VL_W-1:0]   vl_r;
  logic              vm_r;
  logic              mc_r;
  logic [MAX_VL-1:0] mask_r;
  logic              exc_r;
  logic [VL_W-1:0]   vstart_r;

  logic [VL_W-1:0] off1;
  logic [VL_W-1:0] off2;
  logic            in_seq;
  logic [1:0]      act;
  logic [1:0]      msel;
  logic [1:0]      en;
  logic [1:0]      exc_hit;
  logic            exc_any;
  logic [VL_W-1:0] exc_vstart;
  logic            last_grp;
  logic            issue_go;
  logic            start_mc;
  logic            adv_issue;
  logic            mc_complete;
  logic [1:0]      pend;
  logic            all_done;

  assign off1   = offset_r + VL_W'(1);
  assign off2   = offset_r + VL_W'(2);
  assign in_seq = (state == ISSUE) || (state == WAIT_MC);
  assign act    = {in_seq && (off1 < vl_r), in_seq && (offset_r < vl_r)};

  // Active lanes always index below MAX_VL, so the low offset bits suffice;
  // an out-of-range lane1 index is masked off by act[1].
  assign msel    = {mask_r[off1[VL_W-2:0]], mask_r[offset_r[VL_W-2:0]]};
  assign en      = act & ({2{vm_r}} | msel);
  assign exc_hit = lane_exception & act;
  assign exc_any = (exc_hit != 2'b00);
  assign exc_vstart = offset_r + {{(VL_W-1){1'b0}}, ~exc_hit[0]};
  assign last_grp   = (off2 >= vl_r);

  assign issue_go    = (state == ISSUE) && !stall && !exc_any;
  assign start_mc    = issue_go && mc_r && (en != 2'b00);
  assign adv_issue   = issue_go && !start_mc;
  assign mc_complete = (state == WAIT_MC) && !stall && !exc_any && all_done;

  vseq_done_tracker u_done_tracker (
    .CLK       (CLK),
    .RST       (RST),
    .load      (start_mc),
    .load_pend (en),
    .track     (state == WAIT_MC),
    .clear     ((state == WAIT_MC) && (mc_complete || exc_any)),
    .lane_done (lane_done),
    .pend      (pend),
    .all_done  (all_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      offset_r <= '0;
      vl_r     <= '0;
      vm_r     <= 1'b0;
      mc_r     <= 1'b0;
      mask_r   <= '0;
      exc_r    <= 1'b0;
      vstart_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            vl_r     <= vl;
            vm_r     <= vm;
            mc_r     <= fu_multicycle;
            mask_r   <= mask_bits;
            offset_r <= '0;
            exc_r    <= 1'b0;
            vstart_r <= '0;
            state    <= (vl == '0) ? FIN : ISSUE;
          end
        end
        ISSUE: begin
          if (exc_any) begin
            exc_r    <= 1'b1;
            vstart_r <= exc_vstart;
            state    <= FIN;
          end else if (start_mc) begin
            state <= WAIT_MC;
          end else if (adv_issue) begin
            if (last_grp) state <= FIN;
            else          offset_r <= off2;
          end
        end
        WAIT_MC: begin
          // An exception outranks a completion arriving in the same cycle.
          if (exc_any) begin
            exc_r    <= 1'b1;
            vstart_r <= exc_vstart;
            state    <= FIN;
          end else if (mc_complete) begin
            if (last_grp) begin
              state <= FIN;
            end else begin
              offset_r <= off2;
              state    <= ISSUE;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready       = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);
  assign exception   = (state == FIN) && exc_r;
  assign vstart_out  = (state == FIN) ? vstart_r : '0;
  assign offset      = offset_r;
  assign lane_active = act;
  assign lane_start  = start_mc ? en : 2'b00;
  assign wen         = adv_issue ? en : (mc_complete ? pend : 2'b00);

endmodule
`default_nettype wire
